// File: rtl/axis_ingress.sv
// AXI4-Stream ingress slice: registered two-entry skid buffer, maximum frame length
// enforcement (truncate and discard), and per-beat control strobes for the parser.
module axis_ingress #(
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BEATS  = 190,
    parameter int BEAT_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] axis_tdata_out,
    output logic                  axis_tvalid_out,
    input  logic                  axis_tready_out,
    output logic                  axis_tlast_out,
    output logic                  beat_accept,
    output logic                  frame_start,
    output logic                  frame_end,
    output logic [BEAT_CNT_W-1:0] beat_index,
    output logic                  oversize
);

    typedef enum logic [1:0] {
        BUF_EMPTY,
        BUF_ONE,
        BUF_FULL
    } buf_state_e;

    localparam logic [BEAT_CNT_W-1:0] LAST_IN_CNT = BEAT_CNT_W'(MAX_BEATS - 1);

    buf_state_e            r_buf_state;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic                  r_out_last;
    logic                  r_skid_last;
    logic                  r_tready;
    logic                  r_drop;
    logic                  r_oversize;
    logic                  r_first;
    logic [BEAT_CNT_W-1:0] r_in_cnt;
    logic [BEAT_CNT_W-1:0] r_beat_index;

    buf_state_e            w_buf_next;
    logic                  w_accept;
    logic                  w_write;
    logic                  w_trunc;
    logic                  w_in_last;
    logic                  w_pop;
    logic                  w_drop_next;

    assign w_accept  = s_axis_tvalid & r_tready;
    assign w_write   = w_accept & ~r_drop;
    // The beat that reaches the length limit without tlast is kept, but closes the frame.
    assign w_trunc   = w_write & ~s_axis_tlast & (r_in_cnt == LAST_IN_CNT);
    assign w_in_last = s_axis_tlast | w_trunc;
    assign w_pop     = (r_buf_state != BUF_EMPTY) & axis_tready_out;

    assign w_drop_next = r_drop ? ~(w_accept & s_axis_tlast) : w_trunc;

    always_comb begin
        w_buf_next = r_buf_state;
        case (r_buf_state)
            BUF_EMPTY: if (w_write) w_buf_next = BUF_ONE;
            BUF_ONE: begin
                if (w_write && !w_pop)      w_buf_next = BUF_FULL;
                else if (!w_write && w_pop) w_buf_next = BUF_EMPTY;
            end
            BUF_FULL:  if (w_pop) w_buf_next = BUF_ONE;
            default:   w_buf_next = BUF_EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_state <= BUF_EMPTY;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_tready    <= 1'b1;
        end else begin
            r_buf_state <= w_buf_next;
            r_tready    <= (w_buf_next != BUF_FULL) | w_drop_next;
            case (r_buf_state)
                BUF_EMPTY: if (w_write) begin
                    r_out_data <= s_axis_tdata;
                    r_out_last <= w_in_last;
                end
                BUF_ONE: if (w_write && w_pop) begin
                    r_out_data <= s_axis_tdata;
                    r_out_last <= w_in_last;
                end
                BUF_FULL: if (w_pop) begin
                    r_out_data <= r_skid_data;
                    r_out_last <= r_skid_last;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the skid entry needs no reset; it is only read after the FULL state has written it.
    always_ff @(posedge clk) begin
        if (r_buf_state == BUF_ONE && w_write && !w_pop) begin
            r_skid_data <= s_axis_tdata;
            r_skid_last <= w_in_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop     <= 1'b0;
            r_in_cnt   <= '0;
            r_oversize <= 1'b0;
        end else begin
            r_drop     <= w_drop_next;
            r_oversize <= w_trunc;
            if (w_accept) begin
                if (r_drop || s_axis_tlast || w_trunc) r_in_cnt <= '0;
                else                                   r_in_cnt <= r_in_cnt + BEAT_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_first      <= 1'b1;
            r_beat_index <= '0;
        end else if (frame_end) begin
            r_first      <= 1'b1;
            r_beat_index <= '0;
        end else if (beat_accept) begin
            r_first      <= 1'b0;
            r_beat_index <= r_beat_index + BEAT_CNT_W'(1);
        end
    end

    assign s_axis_tready   = r_tready;
    assign axis_tdata_out  = r_out_data;
    assign axis_tlast_out  = r_out_last;
    assign axis_tvalid_out = (r_buf_state != BUF_EMPTY);
    assign beat_accept     = axis_tvalid_out & axis_tready_out;
    assign frame_start     = beat_accept & r_first;
    assign frame_end       = beat_accept & r_out_last;
    assign beat_index      = r_beat_index;
    assign oversize        = r_oversize;

endmodule

// File: tb/tb_axis_ingress.sv
// Self-checking bench for axis_ingress: directed scenarios plus randomized frames and
// sink backpressure, checked against a frame-level reference model.
module tb_axis_ingress;

    localparam int DW   = 64;
    localparam int MAXB = 8;
    localparam int CW   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [DW-1:0] axis_tdata_out;
    logic          axis_tvalid_out;
    logic          axis_tready_out;
    logic          axis_tlast_out;
    logic          beat_accept;
    logic          frame_start;
    logic          frame_end;
    logic [CW-1:0] beat_index;
    logic          oversize;

    axis_ingress #(.DATA_WIDTH(DW), .MAX_BEATS(MAXB), .BEAT_CNT_W(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .s_axis_tlast    (s_axis_tlast),
        .axis_tdata_out  (axis_tdata_out),
        .axis_tvalid_out (axis_tvalid_out),
        .axis_tready_out (axis_tready_out),
        .axis_tlast_out  (axis_tlast_out),
        .beat_accept     (beat_accept),
        .frame_start     (frame_start),
        .frame_end       (frame_end),
        .beat_index      (beat_index),
        .oversize        (oversize)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            idx;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] frame_data [0:15];
    int            n_checks = 0;
    int            n_errors = 0;
    int            exp_ov = 0;
    int            ov_seen = 0;
    int            ready_low = 0;
    int            valid_cycles = 0;
    int            cyc = 0;
    int            mode = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: a frame longer than MAXB keeps its first MAXB beats, the last one marked tlast.
    task automatic push_frame(input int len);
        int n_out;
        n_out = (len > MAXB) ? MAXB : len;
        for (int i = 0; i < n_out; i++)
            exp_q.push_back('{data: frame_data[i], last: (i == n_out - 1), idx: i});
        if (len > MAXB) exp_ov++;
    endtask

    function automatic logic ready_val();
        case (mode)
            0:       return 1'b1;
            1:       return ($urandom_range(0, 99) < 70);
            2:       return !((cyc % 4) == 1 || (cyc % 4) == 2);
            default: return 1'b0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        axis_tready_out = ready_val();
    endtask

    task automatic set_mode(input int m);
        mode = m;
        axis_tready_out = ready_val();
    endtask

    task automatic send_frame(input int len, input bit gaps);
        logic hs;
        int   guard;
        for (int i = 0; i < len; i++) begin
            while (gaps && $urandom_range(0, 3) == 0) begin
                s_axis_tvalid = 1'b0;
                tick();
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = frame_data[i];
            s_axis_tlast  = (i == len - 1);
            guard = 0;
            do begin
                hs = s_axis_tready;
                tick();
                guard++;
            end while (!hs && guard < 200);
            if (!hs) check("accept_timeout", {63'd0, hs}, 64'd1);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 400) begin
            tick();
            guard++;
        end
        check("drain_empty", exp_q.size(), 0);
        tick();
    endtask

    task automatic fill_random(input int len);
        for (int i = 0; i < len; i++) frame_data[i] = {$urandom, $urandom};
    endtask

    // Output monitor: in-order data, control strobes and stall stability.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", axis_tvalid_out, 1);
                    check("hold_data", axis_tdata_out, prev_data);
                    check("hold_last", axis_tlast_out, prev_last);
                end
                prev_stall = axis_tvalid_out && !axis_tready_out;
                prev_data  = axis_tdata_out;
                prev_last  = axis_tlast_out;
                if (oversize) ov_seen++;
                if (!s_axis_tready) ready_low++;
                if (axis_tvalid_out) valid_cycles++;
                check("beat_accept", beat_accept, axis_tvalid_out & axis_tready_out);
                if (axis_tvalid_out && axis_tready_out) begin
                    check("beat_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("out_data", axis_tdata_out, e.data);
                        check("out_last", axis_tlast_out, e.last);
                        check("beat_index", beat_index, e.idx);
                        check("frame_start", frame_start, e.idx == 0);
                        check("frame_end", frame_end, e.last);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst             = 1'b1;
        s_axis_tvalid   = 1'b0;
        s_axis_tdata    = '0;
        s_axis_tlast    = 1'b0;
        axis_tready_out = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_tready", s_axis_tready, 1);
        check("rst_tvalid", axis_tvalid_out, 0);
        check("rst_tdata", axis_tdata_out, 0);
        check("rst_tlast", axis_tlast_out, 0);
        check("rst_beat_index", beat_index, 0);
        check("rst_oversize", oversize, 0);

        // Single-beat frame: one-cycle latency, start and end together.
        set_mode(0);
        frame_data[0] = 64'hA5;
        push_frame(1);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 64'hA5;
        s_axis_tlast  = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        check("single_valid", axis_tvalid_out, 1);
        check("single_data", axis_tdata_out, 64'hA5);
        check("single_start", frame_start, 1);
        check("single_end", frame_end, 1);
        check("single_index", beat_index, 0);
        drain();

        // Maximum-length frame at full rate: no bubbles, no backpressure, no truncation.
        fill_random(8);
        push_frame(8);
        ready_low    = 0;
        valid_cycles = 0;
        send_frame(8, 1'b0);
        drain();
        check("full_rate_ready_low", ready_low, 0);
        check("full_rate_valid_cycles", valid_cycles, 8);
        check("max_len_oversize", ov_seen, exp_ov);

        // Sink stalls 1,0,0,1: input side must see backpressure once the buffer fills.
        set_mode(2);
        fill_random(6);
        push_frame(6);
        ready_low = 0;
        send_frame(6, 1'b0);
        drain();
        check("stall_saw_backpressure", ready_low > 0, 1);

        // Oversize frame of 11 beats, then a 2-beat frame.
        set_mode(0);
        fill_random(11);
        push_frame(11);
        send_frame(11, 1'b0);
        fill_random(2);
        push_frame(2);
        send_frame(2, 1'b0);
        drain();
        check("oversize_count", ov_seen, exp_ov);

        // Reset with the buffer full mid-frame.
        set_mode(3);
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = 64'h1111;
        tick();
        s_axis_tdata  = 64'h2222;
        tick();
        s_axis_tvalid = 1'b0;
        check("full_tready", s_axis_tready, 0);
        check("full_tvalid", axis_tvalid_out, 1);
        check("full_head_data", axis_tdata_out, 64'h1111);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check("midrst_tvalid", axis_tvalid_out, 0);
        check("midrst_tready", s_axis_tready, 1);
        check("midrst_index", beat_index, 0);
        check("midrst_oversize", oversize, 0);
        set_mode(0);
        fill_random(8);
        push_frame(8);
        send_frame(8, 1'b0);
        drain();
        check("post_rst_oversize", ov_seen, exp_ov);

        // Randomized frames, lengths straddling the limit, random gaps and sink backpressure.
        for (int f = 0; f < 40; f++) begin
            int len;
            len = $urandom_range(1, 12);
            fill_random(len);
            push_frame(len);
            set_mode($urandom_range(0, 2));
            send_frame(len, 1'b1);
        end
        set_mode(1);
        drain();
        check("random_oversize_count", ov_seen, exp_ov);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/axis_ingress.md
Name: axis_ingress

Overview:
AXI4-Stream ingress slice at the receive edge of the Ethernet parser. It is the counterpart of the egress stage.
- Accepts the external slave stream through a fully registered two-entry skid buffer.
- Enforces a maximum frame length by truncating and discarding oversize frames.
- Presents the cleaned internal stream plus the per-beat control strobes (beat_accept, frame_start, frame_end, beat_index) used by the parser and the egress metadata logic.

Parameters:
DATA_WIDTH, 64, tdata width in bits
MAX_BEATS, 190, maximum beats per frame; beat MAX_BEATS is the first one discarded
BEAT_CNT_W, 8, width of beat counters; must satisfy 2**BEAT_CNT_W > MAX_BEATS

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
s_axis_tdata  in  DATA_WIDTH  external stream data
s_axis_tvalid  in  1  external valid
s_axis_tready  out  1  external ready, driven from a register
s_axis_tlast  in  1  external last
axis_tdata_out  out  DATA_WIDTH  internal stream data
axis_tvalid_out  out  1  internal valid
axis_tready_out  in  1  internal ready
axis_tlast_out  out  1  internal last (forced on truncation)
beat_accept  out  1  comb: axis_tvalid_out & axis_tready_out
frame_start  out  1  comb: beat_accept on the first beat of a frame
frame_end  out  1  comb: beat_accept & axis_tlast_out
beat_index  out  BEAT_CNT_W  index of the current output beat within its frame, starting at 0
oversize  out  1  one-cycle registered pulse when a frame is truncated

Behaviour:
- Reset (clk edge with rst=1) has priority over every other event.
  - Outputs after reset: s_axis_tready=1, axis_tvalid_out=0, axis_tdata_out=0, axis_tlast_out=0, beat_index=0, oversize=0.
  - Internal state after reset: buffer EMPTY, drop state IDLE, input beat counter 0, output "first beat" flag set.
  - A reset mid-frame discards all buffered beats; the next accepted input beat starts a new frame.
- Skid buffer has three states: EMPTY, ONE (output register valid), FULL (output register and skid register valid).
  - s_axis_tready = (state != FULL), registered.
  - Input accept is s_axis_tvalid & s_axis_tready. Output pop is beat_accept.
  - EMPTY + accept -> ONE. Input data appears on the output one cycle after acceptance (latency 1).
  - ONE + accept, no pop -> FULL.
  - ONE + accept + pop -> ONE; the new beat goes directly to the output register.
  - ONE + pop only -> EMPTY.
  - FULL + pop -> ONE; the skid beat moves to the output register.
  - FULL never accepts.
  - Sustains 1 beat/cycle when axis_tready_out is held high. No beat is lost or duplicated under any ready pattern.
- Output held stable: tdata, tlast and tvalid do not change while axis_tvalid_out=1 and axis_tready_out=0.
- Length enforcement is done on the input side, with counter in_cnt of accepted beats in the current frame.
  - Normal beat: in_cnt increments; it clears to 0 on an accepted beat with s_axis_tlast=1.
  - Accepted beat with in_cnt == MAX_BEATS-1 and s_axis_tlast=0: the beat is written into the buffer with tlast forced to 1, oversize pulses the next cycle, and the block enters DROP.
  - In DROP, s_axis_tready=1 regardless of buffer state and accepted beats are discarded (not written).
  - DROP exits to IDLE on an accepted beat with s_axis_tlast=1; in_cnt returns to 0.
  - A beat with tlast=1 exactly at in_cnt == MAX_BEATS-1 is a legal maximum-length frame: no truncation, no oversize pulse.
- Output-side tracking:
  - A first flag is set at reset and after frame_end; it clears on any other beat_accept.
  - frame_start = beat_accept & first.
  - beat_index increments on beat_accept and resets to 0 on frame_end.
  - A single-beat frame asserts frame_start and frame_end in the same cycle.

Test Plan:
- Single-beat frame 0xA5 with tlast, tready_out=1 -> output valid 1 cycle later with tdata=0xA5; frame_start=frame_end=1 in the same cycle; beat_index=0.
- 8-beat frame, tready_out=1 continuously -> 8 consecutive output cycles with no bubbles; beat_index 0..7; s_axis_tready stays 1.
- 6-beat frame with tready_out toggling 1,0,0,1 -> s_axis_tready drops only when FULL; output order and data exact; no duplicates; data held stable during stalls.
- MAX_BEATS=4, 7-beat frame (D0..D6) followed by a 2-beat frame -> output D0..D3 with tlast on D3; one oversize pulse; D4..D6 discarded; the next frame starts at beat_index 0 with frame_start=1.
- MAX_BEATS=4, 4-beat frame with tlast on beat 3 -> passes intact; oversize=0.
- rst asserted for 1 cycle after beat 2 of a 5-beat frame with the buffer FULL -> next cycle axis_tvalid_out=0 and s_axis_tready=1; the next input beat produces frame_start with beat_index=0.
